// File: rtl/reduce_pkg.sv
// Shared types and constants for the reduction tile sequencer and its result FIFO.
package reduce_pkg;

   localparam int unsigned TILE_N = 4;
   localparam int unsigned ACC_W  = 32;

   localparam logic [1:0] MODE_MAC   = 2'b00;
   localparam logic [1:0] MODE_OUTER = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_STREAM,
      ST_DRAIN
   } state_t;

   typedef struct packed {
      logic live;
      logic is_clear;
      logic is_last;
   } tag_t;

   typedef logic signed [ACC_W-1:0] acc_word_t;
   typedef acc_word_t [TILE_N-1:0]  acc_vec_t;
   typedef acc_vec_t  [TILE_N-1:0]  acc_tile_t;

endpackage

// File: rtl/reduction_result_fifo.sv
// Synchronous vector FIFO with occupancy count; DEPTH must be a power of two.
module reduction_result_fifo
   import reduce_pkg::*;
#(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             valid,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign valid   = (count != '0);
   assign do_pop  = pop && valid;
   assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/reduction_tile_sequencer.sv
// Feeds partial-sum tiles to the 2-cycle reduction accumulator, sequences clears,
// and captures finished column-sum vectors into a credit-protected result FIFO.
module reduction_tile_sequencer
   import reduce_pkg::*;
#(
   parameter int unsigned TILE_SIZE  = 4,
   parameter int unsigned ACC_WIDTH  = 32,
   parameter int unsigned MAX_KTILES = 256,
   parameter int unsigned RES_DEPTH  = 2,
   localparam int unsigned KCNT_W    = $clog2(MAX_KTILES + 1),
   localparam int unsigned VEC_W     = ACC_WIDTH * TILE_SIZE,
   localparam int unsigned MAT_W     = VEC_W * TILE_SIZE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [1:0]        cfg_mode,
   input  logic [KCNT_W-1:0] cfg_num_k,
   input  logic              tile_valid,
   output logic              tile_ready,
   input  logic [MAT_W-1:0]  tile_data,
   output logic              acc_valid_in,
   output logic [1:0]        acc_mode,
   output logic              acc_clear,
   output logic [MAT_W-1:0]  acc_mat,
   input  logic [VEC_W-1:0]  acc_vec,
   input  logic              acc_valid_out,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [VEC_W-1:0]  res_vec,
   output logic              busy
);

   localparam int unsigned CW = $clog2(RES_DEPTH) + 1;
   localparam int unsigned UW = CW + 2;

   state_t            state;
   state_t            state_nx;
   logic [1:0]        mode_q;
   logic [KCNT_W-1:0] num_k_q;
   logic [KCNT_W-1:0] k_cnt;
   tag_t [2:0]        tags;
   tag_t              new_tag;
   logic              err_sticky;

   logic [CW-1:0]     fifo_count;
   logic [1:0]        inflight;
   logic [UW-1:0]     used;
   logic              has_credit;
   logic              is_mac;
   logic              last_k;
   logic              pipe_empty;
   logic              issue_clear;
   logic              handshake;
   logic              fifo_push;

   assign is_mac     = (mode_q == MODE_MAC);
   assign last_k     = (k_cnt == num_k_q - KCNT_W'(1));
   assign pipe_empty = !(tags[0].live || tags[1].live || tags[2].live);
   assign handshake  = tile_valid && tile_ready;

   // Results already queued plus those still in the accumulator pipe must fit.
   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         inflight = inflight + 2'(tags[i].live && tags[i].is_last);
      end
   end

   assign used       = UW'(fifo_count) + UW'(inflight);
   assign has_credit = (used < UW'(RES_DEPTH));

   always_comb begin
      state_nx    = state;
      cfg_ready   = 1'b0;
      tile_ready  = 1'b0;
      issue_clear = 1'b0;
      case (state)
         ST_IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               state_nx = (cfg_mode == MODE_MAC) ? ST_CLEAR : ST_STREAM;
            end
         end
         ST_CLEAR: begin
            if (has_credit) begin
               issue_clear = 1'b1;
               state_nx    = ST_STREAM;
            end
         end
         ST_STREAM: begin
            tile_ready = (k_cnt < num_k_q) && (is_mac || has_credit);
            if (tile_valid && tile_ready && last_k) begin
               state_nx = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pipe_empty) begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      new_tag          = '0;
      new_tag.live     = handshake || issue_clear;
      new_tag.is_clear = issue_clear;
      new_tag.is_last  = handshake && (!is_mac || last_k);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         mode_q       <= '0;
         num_k_q      <= '0;
         k_cnt        <= '0;
         tags         <= '0;
         err_sticky   <= 1'b0;
         acc_valid_in <= 1'b0;
         acc_clear    <= 1'b0;
         acc_mode     <= '0;
         acc_mat      <= '0;
      end else begin
         state <= state_nx;
         if (state == ST_IDLE && cfg_valid) begin
            mode_q  <= cfg_mode;
            num_k_q <= (cfg_num_k == '0) ? KCNT_W'(1) : cfg_num_k;
            k_cnt   <= '0;
         end else if (handshake) begin
            k_cnt <= k_cnt + KCNT_W'(1);
         end
         acc_valid_in <= handshake;
         acc_clear    <= issue_clear;
         if (handshake) begin
            acc_mat  <= tile_data;
            acc_mode <= mode_q;
         end else if (issue_clear) begin
            acc_mode <= mode_q;
         end
         tags <= {tags[1:0], new_tag};
         if (acc_valid_out != tags[2].live) begin
            err_sticky <= 1'b1;
         end
      end
   end

   // Clear tags also raise valid_out; only last-tile tags carry a finished vector.
   assign fifo_push = tags[2].live && tags[2].is_last && !tags[2].is_clear;

   reduction_result_fifo #(
      .WIDTH (VEC_W),
      .DEPTH (RES_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (acc_vec),
      .pop       (res_ready),
      .head      (res_vec),
      .valid     (res_valid),
      .count     (fifo_count)
   );

   assign busy = (state != ST_IDLE) || !pipe_empty;

endmodule

// File: tb/tb_reduction_tile_sequencer.sv
// Self-checking bench: emulated accumulator, job-level result model, directed and random jobs.
module tb_reduction_tile_sequencer;
   import reduce_pkg::*;

   localparam int TS    = 4;
   localparam int AWD   = 32;
   localparam int KW    = 9;
   localparam int RD    = 2;
   localparam int VEC_W = AWD * TS;
   localparam int MAT_W = VEC_W * TS;

   logic             clk;
   logic             rst_n;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [1:0]       cfg_mode;
   logic [KW-1:0]    cfg_num_k;
   logic             tile_valid;
   logic             tile_ready;
   logic [MAT_W-1:0] tile_data;
   logic             acc_valid_in;
   logic [1:0]       acc_mode;
   logic             acc_clear;
   logic [MAT_W-1:0] acc_mat;
   logic [VEC_W-1:0] acc_vec;
   logic             acc_valid_out;
   logic             res_valid;
   logic             res_ready;
   logic [VEC_W-1:0] res_vec;
   logic             busy;

   reduction_tile_sequencer #(
      .TILE_SIZE  (TS),
      .ACC_WIDTH  (AWD),
      .MAX_KTILES (256),
      .RES_DEPTH  (RD)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_mode      (cfg_mode),
      .cfg_num_k     (cfg_num_k),
      .tile_valid    (tile_valid),
      .tile_ready    (tile_ready),
      .tile_data     (tile_data),
      .acc_valid_in  (acc_valid_in),
      .acc_mode      (acc_mode),
      .acc_clear     (acc_clear),
      .acc_mat       (acc_mat),
      .acc_vec       (acc_vec),
      .acc_valid_out (acc_valid_out),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_vec       (res_vec),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b", nm, act, exp);
      end
   endtask

   task automatic chkn(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic chkvec(input string nm, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic chkmat(input string nm, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // ---------------- data helpers ----------------
   function automatic logic [VEC_W-1:0] colsum(input logic [MAT_W-1:0] m);
      logic [VEC_W-1:0] v;
      logic [AWD-1:0]   s;
      v = '0;
      for (int c = 0; c < TS; c++) begin
         s = '0;
         for (int r = 0; r < TS; r++) s = s + m[(r*TS+c)*AWD +: AWD];
         v[c*AWD +: AWD] = s;
      end
      return v;
   endfunction

   function automatic logic [VEC_W-1:0] vadd(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
      logic [VEC_W-1:0] v;
      for (int c = 0; c < TS; c++) v[c*AWD +: AWD] = a[c*AWD +: AWD] + b[c*AWD +: AWD];
      return v;
   endfunction

   function automatic logic [VEC_W-1:0] vconst(input int x);
      logic [VEC_W-1:0] v;
      for (int c = 0; c < TS; c++) v[c*AWD +: AWD] = AWD'(x);
      return v;
   endfunction

   function automatic logic [MAT_W-1:0] mk_const(input int x);
      logic [MAT_W-1:0] m;
      for (int i = 0; i < TS*TS; i++) m[i*AWD +: AWD] = AWD'(x);
      return m;
   endfunction

   function automatic logic [MAT_W-1:0] mk_cols();
      logic [MAT_W-1:0] m;
      for (int r = 0; r < TS; r++)
         for (int c = 0; c < TS; c++) m[(r*TS+c)*AWD +: AWD] = AWD'(c + 1);
      return m;
   endfunction

   function automatic logic [MAT_W-1:0] mk_rand();
      logic [MAT_W-1:0] m;
      for (int i = 0; i < TS*TS; i++) m[i*AWD +: AWD] = $urandom;
      return m;
   endfunction

   // ---------------- emulated accumulator (2-cycle latency) ----------------
   logic             p1_v;
   logic [VEC_W-1:0] p1_vec;
   logic [VEC_W-1:0] accum;

   always @(posedge clk) begin
      if (!rst_n) begin
         acc_valid_out <= 1'b0;
         acc_vec       <= '0;
         p1_v          <= 1'b0;
         p1_vec        <= '0;
         accum         <= '0;
      end else begin
         acc_valid_out <= p1_v;
         acc_vec       <= p1_vec;
         p1_v          <= acc_valid_in || acc_clear;
         if (acc_clear) begin
            accum  <= '0;
            p1_vec <= '0;
         end else if (acc_valid_in) begin
            if (acc_mode == MODE_MAC) begin
               accum  <= vadd(accum, colsum(acc_mat));
               p1_vec <= vadd(accum, colsum(acc_mat));
            end else begin
               p1_vec <= colsum(acc_mat);
            end
         end
      end
   end

   // ---------------- result-ready driver ----------------
   int   rr_mode = 0;
   logic rr_val  = 1'b1;
   always @(negedge clk) res_ready = (rr_mode == 1) ? 1'($urandom_range(0, 1)) : rr_val;

   // ---------------- job-level model and compare process ----------------
   logic [VEC_W-1:0] exp_q[$];
   logic [VEC_W-1:0] pop_log[$];
   int               cyc         = 0;
   int               fin_cyc     = -100;
   int               clears_seen = 0;
   logic             prev_rst_low = 1'b1;
   logic             prev_hs      = 1'b0;
   logic [MAT_W-1:0] prev_tile;
   logic [1:0]       prev_mode;
   logic [1:0]       jmode;
   int               jnk;
   int               jk;
   logic [VEC_W-1:0] jsum;

   initial begin
      forever begin
         @(negedge clk);
         #2;
         cyc++;
         if (prev_rst_low) begin
            chk1("rst_acc_valid_in", acc_valid_in, 1'b0);
            chk1("rst_acc_clear", acc_clear, 1'b0);
            chkn("rst_acc_mode", int'(acc_mode), 0);
            chkmat("rst_acc_mat", acc_mat, '0);
            chk1("rst_res_valid", res_valid, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_cfg_ready", cfg_ready, 1'b1);
            chk1("rst_tile_ready", tile_ready, 1'b0);
         end else begin
            chk1("acc_valid_in", acc_valid_in, prev_hs);
            if (prev_hs) begin
               chkmat("acc_mat", acc_mat, prev_tile);
               chkn("acc_mode", int'(acc_mode), int'(prev_mode));
            end
            chk1("clear_with_valid", acc_clear && acc_valid_in, 1'b0);
            if (acc_clear) clears_seen++;
            if (cyc == fin_cyc + 4) chk1("busy_draining", busy, 1'b1);
            if (cyc == fin_cyc + 5) chk1("busy_idle", busy, 1'b0);
            if (res_valid) begin
               chk1("res_has_expect", exp_q.size() != 0, 1'b1);
               if (res_ready && exp_q.size() != 0) begin
                  chkvec("res_vec", res_vec, exp_q[0]);
                  pop_log.push_back(res_vec);
                  void'(exp_q.pop_front());
               end
            end
         end
         prev_hs = 1'b0;
         if (!rst_n) begin
            exp_q.delete();
            fin_cyc = -100;
         end else begin
            if (cfg_valid && cfg_ready) begin
               jmode = cfg_mode;
               jnk   = (cfg_num_k == '0) ? 1 : int'(cfg_num_k);
               jk    = 0;
               jsum  = '0;
            end
            if (tile_valid && tile_ready) begin
               prev_hs   = 1'b1;
               prev_tile = tile_data;
               prev_mode = jmode;
               jk++;
               if (jmode == MODE_MAC) begin
                  jsum = vadd(jsum, colsum(tile_data));
                  if (jk == jnk) exp_q.push_back(jsum);
               end else begin
                  exp_q.push_back(colsum(tile_data));
               end
               if (jk == jnk) fin_cyc = cyc;
            end
         end
         prev_rst_low = !rst_n;
      end
   end

   // ---------------- stimulus tasks (start and end at a falling edge) ----------------
   task automatic start_job(input logic [1:0] m, input int nk);
      int n;
      n = 0;
      cfg_valid = 1'b1;
      cfg_mode  = m;
      cfg_num_k = KW'(nk);
      #1;
      while (!cfg_ready && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 300) chkn("cfg_timeout", n, 0);
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic send_tile(input logic [MAT_W-1:0] d, input int gap);
      int n;
      n = 0;
      tile_valid = 1'b0;
      repeat (gap) @(negedge clk);
      tile_valid = 1'b1;
      tile_data  = d;
      #1;
      while (!tile_ready && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 300) chkn("tile_timeout", n, 0);
      @(negedge clk);
      tile_valid = 1'b0;
   endtask

   task automatic wait_done(input logic need_empty);
      int n;
      n = 0;
      #1;
      while ((busy || (need_empty && exp_q.size() != 0)) && n < 500) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 500) chkn("drain_timeout", n, 0);
      @(negedge clk);
   endtask

   int p0;
   int c0;
   int n_bp;
   int nk_r;
   logic [1:0] m_r;
   logic [VEC_W-1:0] cols_exp;

   initial begin
      rst_n      = 1'b0;
      cfg_valid  = 1'b0;
      cfg_mode   = '0;
      cfg_num_k  = '0;
      tile_valid = 1'b0;
      tile_data  = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // MAC, three tiles: one clear, one result of 4+8+12
      p0 = pop_log.size();
      c0 = clears_seen;
      start_job(MODE_MAC, 3);
      send_tile(mk_const(1), 0);
      send_tile(mk_const(2), 0);
      send_tile(mk_const(3), 0);
      wait_done(1'b1);
      chkn("mac_result_count", pop_log.size() - p0, 1);
      chkvec("mac_result", pop_log[pop_log.size()-1], vconst(24));
      chkn("mac_clear_pulses", clears_seen - c0, 1);

      // OUTER, two tiles: two results, no clear
      p0 = pop_log.size();
      c0 = clears_seen;
      start_job(MODE_OUTER, 2);
      send_tile(mk_const(2), 0);
      send_tile(mk_const(5), 0);
      wait_done(1'b1);
      chkn("outer_result_count", pop_log.size() - p0, 2);
      chkvec("outer_result0", pop_log[p0], vconst(8));
      chkvec("outer_result1", pop_log[p0+1], vconst(20));
      chkn("outer_clear_pulses", clears_seen - c0, 0);

      // Backpressure: FIFO full after two OUTER jobs blocks the third
      p0 = pop_log.size();
      rr_val = 1'b0;
      @(negedge clk);
      start_job(2'b10, 1);
      send_tile(mk_const(1), 0);
      wait_done(1'b0);
      start_job(2'b11, 1);
      send_tile(mk_const(2), 0);
      wait_done(1'b0);
      start_job(MODE_OUTER, 1);
      tile_valid = 1'b1;
      tile_data  = mk_const(3);
      for (int i = 0; i < 8; i++) begin
         #1;
         chk1("bp_tile_ready", tile_ready, 1'b0);
         @(negedge clk);
      end
      rr_val = 1'b1;
      n_bp = 0;
      #1;
      while (!tile_ready && n_bp < 50) begin
         @(negedge clk);
         #1;
         n_bp++;
      end
      chk1("bp_resume", tile_ready, 1'b1);
      @(negedge clk);
      tile_valid = 1'b0;
      wait_done(1'b1);
      chkn("bp_result_count", pop_log.size() - p0, 3);
      chkvec("bp_result0", pop_log[p0], vconst(4));
      chkvec("bp_result1", pop_log[p0+1], vconst(8));
      chkvec("bp_result2", pop_log[p0+2], vconst(12));

      // num_k = 0 behaves as a single-tile MAC job
      p0 = pop_log.size();
      start_job(MODE_MAC, 0);
      send_tile(mk_cols(), 0);
      wait_done(1'b1);
      for (int c = 0; c < TS; c++) cols_exp[c*AWD +: AWD] = AWD'(4 * (c + 1));
      chkn("k0_result_count", pop_log.size() - p0, 1);
      chkvec("k0_result", pop_log[pop_log.size()-1], cols_exp);

      // Sparse tile_valid with a negative tile
      p0 = pop_log.size();
      start_job(MODE_MAC, 4);
      send_tile(mk_const(1), 2);
      send_tile(mk_const(1), 2);
      send_tile(mk_const(-1), 2);
      send_tile(mk_const(1), 2);
      wait_done(1'b1);
      chkn("gap_result_count", pop_log.size() - p0, 1);
      chkvec("gap_result", pop_log[pop_log.size()-1], vconst(8));

      // Reset in the middle of a MAC stream, then a fresh job
      start_job(MODE_MAC, 4);
      send_tile(mk_const(7), 0);
      send_tile(mk_const(9), 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      p0 = pop_log.size();
      start_job(MODE_MAC, 2);
      send_tile(mk_const(3), 0);
      send_tile(mk_const(4), 0);
      wait_done(1'b1);
      chkn("post_rst_result_count", pop_log.size() - p0, 1);
      chkvec("post_rst_result", pop_log[pop_log.size()-1], vconst(28));

      // Random jobs with random consumer stalls
      rr_mode = 1;
      for (int j = 0; j < 30; j++) begin
         m_r  = ($urandom_range(0, 1) == 0) ? MODE_MAC : 2'($urandom_range(1, 3));
         nk_r = $urandom_range(0, 6);
         start_job(m_r, nk_r);
         for (int t = 0; t < ((nk_r == 0) ? 1 : nk_r); t++) send_tile(mk_rand(), $urandom_range(0, 2));
      end
      wait_done(1'b1);
      rr_mode = 0;
      rr_val  = 1'b1;
      repeat (3) @(negedge clk);
      chkn("model_queue_empty", exp_q.size(), 0);
      chk1("acc_tag_align", dut.err_sticky, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
